// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the multi-slot alarm controller.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } alarm_state_t;

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = '0;

  function automatic bcd_time_t pack_time(input logic [3:0] ms_hr, input logic [3:0] ls_hr,
                                          input logic [3:0] ms_min, input logic [3:0] ls_min);
    bcd_time_t t;
    t.ms_hr  = ms_hr;
    t.ls_hr  = ls_hr;
    t.ms_min = ms_min;
    t.ls_min = ls_min;
    return t;
  endfunction

endpackage

// File: rtl/alarm_match.sv
// Combinational compare of every enabled alarm slot against the current time;
// the lowest-numbered matching slot is reported.
module alarm_match
  import alarm_clock_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2
) (
  input  bcd_time_t [NUM_ALARMS-1:0] slots,
  input  logic      [NUM_ALARMS-1:0] enables,
  input  bcd_time_t                  cur_time,
  output logic                       match_any,
  output logic      [IDX_W-1:0]      match_idx
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (enables[i] && (slots[i] == cur_time)) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-slot alarm controller: slot storage, time-change detection and ring/snooze FSM.
// Optional feature macro ALARM_SNOOZE_LIMIT_EN caps snoozes per ring event at MAX_SNOOZES.
module multi_alarm_ctrl #(
  parameter int NUM_ALARMS     = 4,
  parameter int RING_MINUTES   = 5,
  parameter int SNOOZE_MINUTES = 9,
  parameter int MAX_SNOOZES    = 3,
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  one_minute,
  input  logic [3:0]            current_time_ms_hr,
  input  logic [3:0]            current_time_ls_hr,
  input  logic [3:0]            current_time_ms_min,
  input  logic [3:0]            current_time_ls_min,
  input  logic [3:0]            new_alarm_ms_hr,
  input  logic [3:0]            new_alarm_ls_hr,
  input  logic [3:0]            new_alarm_ms_min,
  input  logic [3:0]            new_alarm_ls_min,
  input  logic                  load_new_alarm,
  input  logic                  alarm_disable,
  input  logic [IDX_W-1:0]      alarm_sel,
  input  logic                  snooze_button,
  input  logic                  stop_button,
  output logic [3:0]            alarm_time_ms_hr,
  output logic [3:0]            alarm_time_ls_hr,
  output logic [3:0]            alarm_time_ms_min,
  output logic [3:0]            alarm_time_ls_min,
  output logic [NUM_ALARMS-1:0] alarm_enabled,
  output logic                  alarm_sound,
  output logic [IDX_W-1:0]      active_alarm
);
  import alarm_clock_pkg::*;

  localparam int RC_W = (RING_MINUTES > 1) ? $clog2(RING_MINUTES) : 1;
  localparam int ST_W = $clog2(SNOOZE_MINUTES + 1);
  localparam logic [RC_W-1:0] RING_LAST   = RC_W'((RING_MINUTES > 0) ? RING_MINUTES - 1 : 0);
  localparam logic [ST_W-1:0] SNOOZE_LOAD = ST_W'(SNOOZE_MINUTES);

  bcd_time_t [NUM_ALARMS-1:0] slots;
  logic      [NUM_ALARMS-1:0] enables;
  bcd_time_t                  prev_time;
  bcd_time_t                  current_time;
  bcd_time_t                  new_alarm;
  bcd_time_t                  readback;
  alarm_state_t               state;
  logic [RC_W-1:0]            ring_cnt;
  logic [ST_W-1:0]            snooze_tmr;
  logic                       sel_valid;
  logic                       time_changed;
  logic                       match_any;
  logic [IDX_W-1:0]           match_idx;
  logic                       hit;
  logic                       end_event;
  logic                       snooze_ok;

  assign current_time = pack_time(current_time_ms_hr, current_time_ls_hr,
                                  current_time_ms_min, current_time_ls_min);
  assign new_alarm    = pack_time(new_alarm_ms_hr, new_alarm_ls_hr,
                                  new_alarm_ms_min, new_alarm_ls_min);
  assign sel_valid    = int'(alarm_sel) < NUM_ALARMS;

  // Load has priority over disable; an out-of-range selector touches nothing.
  always_ff @(posedge clock) begin
    if (reset) begin
      slots   <= '0;
      enables <= '0;
    end else if (sel_valid) begin
      if (load_new_alarm) begin
        slots[alarm_sel]   <= new_alarm;
        enables[alarm_sel] <= 1'b1;
      end else if (alarm_disable) begin
        enables[alarm_sel] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) prev_time <= TIME_ZERO;
    else       prev_time <= current_time;
  end

  assign readback          = sel_valid ? slots[alarm_sel] : TIME_ZERO;
  assign alarm_time_ms_hr  = readback.ms_hr;
  assign alarm_time_ls_hr  = readback.ls_hr;
  assign alarm_time_ms_min = readback.ms_min;
  assign alarm_time_ls_min = readback.ls_min;
  assign alarm_enabled     = enables;

  alarm_match #(
    .NUM_ALARMS(NUM_ALARMS),
    .IDX_W     (IDX_W)
  ) u_match (
    .slots    (slots),
    .enables  (enables),
    .cur_time (current_time),
    .match_any(match_any),
    .match_idx(match_idx)
  );

  // A matching slot only fires on the cycle the time actually moves.
  assign time_changed = current_time != prev_time;
  assign hit          = time_changed & match_any;
  assign end_event    = stop_button |
                        (alarm_disable & ~load_new_alarm & sel_valid & (alarm_sel == active_alarm));

`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam int SC_W = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;
  logic [SC_W-1:0] snooze_cnt;
  assign snooze_ok = snooze_cnt != SC_W'(MAX_SNOOZES);

  always_ff @(posedge clock) begin
    if (reset) begin
      snooze_cnt <= '0;
    end else if ((state == ST_IDLE && !stop_button && hit) ||
                 (state == ST_SNOOZED && !end_event && hit)) begin
      snooze_cnt <= '0;
    end else if (state == ST_RINGING && !end_event && snooze_button && snooze_ok) begin
      snooze_cnt <= snooze_cnt + 1'b1;
    end
  end
`else
  assign snooze_ok = 1'b1;
`endif

  // Ring/snooze FSM; event priority is stop > hit > snooze > timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      alarm_sound  <= 1'b0;
      active_alarm <= '0;
      ring_cnt     <= '0;
      snooze_tmr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!stop_button && hit) begin
            state        <= ST_RINGING;
            alarm_sound  <= 1'b1;
            active_alarm <= match_idx;
            ring_cnt     <= '0;
          end
        end
        ST_RINGING: begin
          if (end_event) begin
            state       <= ST_IDLE;
            alarm_sound <= 1'b0;
          end else if (snooze_button && snooze_ok) begin
            state       <= ST_SNOOZED;
            alarm_sound <= 1'b0;
            snooze_tmr  <= SNOOZE_LOAD;
          end else if (one_minute) begin
            if (RING_MINUTES > 0 && ring_cnt == RING_LAST) begin
              state       <= ST_IDLE;
              alarm_sound <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 1'b1;
            end
          end
        end
        ST_SNOOZED: begin
          if (end_event) begin
            state       <= ST_IDLE;
            alarm_sound <= 1'b0;
          end else if (hit) begin
            state        <= ST_RINGING;
            alarm_sound  <= 1'b1;
            active_alarm <= match_idx;
            ring_cnt     <= '0;
          end else if (one_minute) begin
            if (snooze_tmr == ST_W'(1)) begin
              state       <= ST_RINGING;
              alarm_sound <= 1'b1;
              ring_cnt    <= '0;
            end else begin
              snooze_tmr <= snooze_tmr - 1'b1;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          alarm_sound <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Self-checking bench for multi_alarm_ctrl: directed scenarios followed by random
// traffic, all compared against an event-level model of the alarm behaviour.
module tb_multi_alarm_ctrl;

  localparam int N      = 6;
  localparam int RING   = 5;
  localparam int SNZ    = 9;
  localparam int MAXSNZ = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        one_minute = 1'b0;
  logic [15:0] cur_time = '0;
  logic [15:0] new_time = '0;
  logic        load_new_alarm = 1'b0;
  logic        alarm_disable = 1'b0;
  logic [2:0]  alarm_sel = '0;
  logic        snooze_button = 1'b0;
  logic        stop_button = 1'b0;
  logic [3:0]  rb_ms_hr, rb_ls_hr, rb_ms_min, rb_ls_min;
  logic [N-1:0] alarm_enabled;
  logic        alarm_sound;
  logic [2:0]  active_alarm;

  int total = 0;
  int bad   = 0;

  // Model state: what a user would observe about slots and the current ring event.
  int          m_slot[N];
  bit          m_en[N];
  bit          m_ringing, m_snoozed;
  int          m_active, m_minutes_rung, m_minutes_left, m_snoozes;
  logic [15:0] m_prev;

  multi_alarm_ctrl #(
    .NUM_ALARMS    (N),
    .RING_MINUTES  (RING),
    .SNOOZE_MINUTES(SNZ),
    .MAX_SNOOZES   (MAXSNZ)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .one_minute         (one_minute),
    .current_time_ms_hr (cur_time[15:12]),
    .current_time_ls_hr (cur_time[11:8]),
    .current_time_ms_min(cur_time[7:4]),
    .current_time_ls_min(cur_time[3:0]),
    .new_alarm_ms_hr    (new_time[15:12]),
    .new_alarm_ls_hr    (new_time[11:8]),
    .new_alarm_ms_min   (new_time[7:4]),
    .new_alarm_ls_min   (new_time[3:0]),
    .load_new_alarm     (load_new_alarm),
    .alarm_disable      (alarm_disable),
    .alarm_sel          (alarm_sel),
    .snooze_button      (snooze_button),
    .stop_button        (stop_button),
    .alarm_time_ms_hr   (rb_ms_hr),
    .alarm_time_ls_hr   (rb_ls_hr),
    .alarm_time_ms_min  (rb_ms_min),
    .alarm_time_ls_min  (rb_ls_min),
    .alarm_enabled      (alarm_enabled),
    .alarm_sound        (alarm_sound),
    .active_alarm       (active_alarm)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep();
    int  hit_slot;
    bit  ends_event;
    bit  may_snooze;
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_slot[i] = 0; m_en[i] = 0; end
      m_ringing = 0; m_snoozed = 0; m_active = 0;
      m_minutes_rung = 0; m_minutes_left = 0; m_snoozes = 0; m_prev = '0;
      return;
    end
    hit_slot = -1;
    if (cur_time != m_prev)
      for (int i = 0; i < N; i++)
        if (hit_slot < 0 && m_en[i] && m_slot[i] == int'(cur_time)) hit_slot = i;
    ends_event = stop_button ||
                 (alarm_disable && !load_new_alarm && alarm_sel < N && int'(alarm_sel) == m_active);
`ifdef ALARM_SNOOZE_LIMIT_EN
    may_snooze = m_snoozes < MAXSNZ;
`else
    may_snooze = 1;
`endif
    if (m_ringing) begin
      if (ends_event) m_ringing = 0;
      else if (snooze_button && may_snooze) begin
        m_ringing = 0; m_snoozed = 1; m_minutes_left = SNZ; m_snoozes++;
      end else if (one_minute) begin
        m_minutes_rung++;
        if (RING > 0 && m_minutes_rung == RING) m_ringing = 0;
      end
    end else if (m_snoozed) begin
      if (ends_event) m_snoozed = 0;
      else if (hit_slot >= 0) begin
        m_snoozed = 0; m_ringing = 1; m_active = hit_slot; m_minutes_rung = 0; m_snoozes = 0;
      end else if (one_minute) begin
        m_minutes_left--;
        if (m_minutes_left == 0) begin m_snoozed = 0; m_ringing = 1; m_minutes_rung = 0; end
      end
    end else if (!stop_button && hit_slot >= 0) begin
      m_ringing = 1; m_active = hit_slot; m_minutes_rung = 0; m_snoozes = 0;
    end
    if (alarm_sel < N) begin
      if (load_new_alarm) begin m_slot[alarm_sel] = int'(new_time); m_en[alarm_sel] = 1; end
      else if (alarm_disable) m_en[alarm_sel] = 0;
    end
    m_prev = cur_time;
  endtask

  task automatic compareAll();
    logic [N-1:0] en_vec;
    logic [15:0]  rb_exp;
    for (int i = 0; i < N; i++) en_vec[i] = m_en[i];
    rb_exp = (alarm_sel < N) ? 16'(m_slot[alarm_sel]) : 16'h0;
    checkOutput("sound", 32'(alarm_sound), 32'(m_ringing));
    checkOutput("active", 32'(active_alarm), 32'(m_active));
    checkOutput("enabled", 32'(alarm_enabled), 32'(en_vec));
    checkOutput("readback", 32'({rb_ms_hr, rb_ls_hr, rb_ms_min, rb_ls_min}), 32'(rb_exp));
  endtask

  // One clock: inputs already set by caller, model steps on the edge, outputs checked 1ns later.
  task automatic applyStimulus();
    @(posedge clock);
    modelStep();
    #1;
    compareAll();
    reset = 0; one_minute = 0; load_new_alarm = 0; alarm_disable = 0;
    snooze_button = 0; stop_button = 0;
  endtask

  task automatic loadSlot(input int sel, input logic [15:0] value);
    alarm_sel = 3'(sel); new_time = value; load_new_alarm = 1;
    applyStimulus();
  endtask

  task automatic setTime(input logic [15:0] value);
    cur_time = value;
    applyStimulus();
  endtask

  task automatic minutes(input int n);
    for (int i = 0; i < n; i++) begin one_minute = 1; applyStimulus(); end
  endtask

  logic [15:0] pool[4] = '{16'h0730, 16'h0600, 16'h0800, 16'h0915};

  initial begin
    reset = 1;
    applyStimulus();
    checkOutput("rst_sound", 32'(alarm_sound), 32'h0);
    checkOutput("rst_enabled", 32'(alarm_enabled), 32'h0);

    // Scenario 1: single slot fires one edge after the time change
    loadSlot(2, 16'h0730);
    setTime(16'h0729);
    checkOutput("t1_quiet", 32'(alarm_sound), 32'h0);
    setTime(16'h0730);
    checkOutput("t1_sound", 32'(alarm_sound), 32'h1);
    checkOutput("t1_active", 32'(active_alarm), 32'h2);
    stop_button = 1; applyStimulus();

    // Scenario 2: two slots at the same time, lowest index wins; stop ends it
    loadSlot(0, 16'h0600);
    loadSlot(3, 16'h0600);
    setTime(16'h0600);
    checkOutput("t2_active", 32'(active_alarm), 32'h0);
    stop_button = 1; applyStimulus();
    checkOutput("t2_stop", 32'(alarm_sound), 32'h0);

    // Scenario 3: auto-timeout after RING minutes, no re-fire while time unchanged
    loadSlot(1, 16'h0605);
    setTime(16'h0605);
    checkOutput("t3_active", 32'(active_alarm), 32'h1);
    minutes(RING - 1);
    checkOutput("t3_still", 32'(alarm_sound), 32'h1);
    minutes(1);
    checkOutput("t3_timeout", 32'(alarm_sound), 32'h0);
    repeat (3) applyStimulus();
    checkOutput("t3_norefire", 32'(alarm_sound), 32'h0);

    // Scenario 4: snooze, re-ring after SNZ minutes, then a fourth snooze
    loadSlot(2, 16'h0800);
    setTime(16'h0800);
    for (int k = 0; k < MAXSNZ; k++) begin
      snooze_button = 1; applyStimulus();
      checkOutput("t4_snoozed", 32'(alarm_sound), 32'h0);
      minutes(SNZ - 1);
      checkOutput("t4_waiting", 32'(alarm_sound), 32'h0);
      minutes(1);
      checkOutput("t4_rering", 32'(alarm_sound), 32'h1);
    end
    snooze_button = 1; applyStimulus();
`ifdef ALARM_SNOOZE_LIMIT_EN
    checkOutput("t4_limit", 32'(alarm_sound), 32'h1);
`else
    checkOutput("t4_nolimit", 32'(alarm_sound), 32'h0);
`endif
    stop_button = 1; applyStimulus();

    // Scenario 5: snooze+stop together, then disabling the active slot while snoozed
    loadSlot(1, 16'h0900);
    setTime(16'h0900);
    snooze_button = 1; stop_button = 1; applyStimulus();
    checkOutput("t5_snzstop", 32'(alarm_sound), 32'h0);
    minutes(SNZ);
    checkOutput("t5_stays", 32'(alarm_sound), 32'h0);
    loadSlot(0, 16'h0901);
    setTime(16'h0901);
    checkOutput("t5_ring", 32'(active_alarm), 32'h0);
    snooze_button = 1; applyStimulus();
    alarm_sel = 0; alarm_disable = 1; applyStimulus();
    minutes(SNZ);
    checkOutput("t5_disabled", 32'(alarm_sound), 32'h0);

    // Scenario 6: reset mid-ring, then an out-of-range slot load
    loadSlot(4, 16'h1000);
    setTime(16'h1000);
    checkOutput("t6_ring", 32'(alarm_sound), 32'h1);
    alarm_sel = 4; reset = 1; applyStimulus();
    checkOutput("t6_sound", 32'(alarm_sound), 32'h0);
    checkOutput("t6_enabled", 32'(alarm_enabled), 32'h0);
    checkOutput("t6_readback", 32'({rb_ms_hr, rb_ls_hr, rb_ms_min, rb_ls_min}), 32'h0);
    loadSlot(6, 16'h1234);
    checkOutput("t6_oor_en", 32'(alarm_enabled), 32'h0);
    checkOutput("t6_oor_rb", 32'({rb_ms_hr, rb_ls_hr, rb_ms_min, rb_ls_min}), 32'h0);

    // Random traffic drawn from a small time pool so hits and collisions are frequent
    for (int c = 0; c < 1500; c++) begin
      reset          = ($urandom % 300) == 0;
      one_minute     = ($urandom % 4) == 0;
      if (($urandom % 6) == 0) cur_time = pool[$urandom % 4];
      new_time       = pool[$urandom % 4];
      load_new_alarm = ($urandom % 10) == 0;
      alarm_disable  = ($urandom % 12) == 0;
      alarm_sel      = 3'($urandom % 8);
      snooze_button  = ($urandom % 8) == 0;
      stop_button    = ($urandom % 25) == 0;
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
